// File: rtl/univ_shifter_pkg.sv
// Shared types and the single-step datapath for univ_shifter.
// Rotate support in the top is gated by UNIV_SHIFTER_ROTATE_EN.
package univ_shifter_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned MAX_W  = 64;
  localparam int unsigned IDX_W  = $clog2(MAX_W);

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROTL = 3'd4,
    MODE_ROTR = 3'd5
  } mode_e;

  // Reserved codes; they complete like HOLD.
  localparam logic [MODE_W-1:0] MODE_RSVD6 = 3'd6;
  localparam logic [MODE_W-1:0] MODE_RSVD7 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // One 1-bit step on the low 'width' bits of data; bits above width must be zero.
  function automatic logic [MAX_W-1:0] shift_step(
    input  logic [MAX_W-1:0] data,
    input  int unsigned      width,
    input  logic             left,
    input  logic             rotate,
    input  logic             ser_in,
    output logic             ser_out
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] res;
    logic             msb;
    logic             lsb;
    logic             fill;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    msb  = data[IDX_W'(width - 1)];
    lsb  = data[0];
    if (left) begin
      ser_out = msb;
      fill    = rotate ? msb : ser_in;
      res     = ((data << 1) | MAX_W'(fill)) & mask;
    end else begin
      ser_out = lsb;
      fill    = rotate ? lsb : ser_in;
      res     = (data >> 1) | (MAX_W'(fill) << (width - 1));
    end
    return res;
  endfunction

endpackage

// File: rtl/univ_shifter.sv
// Universal shift register: hold/load/shift/rotate by a step count, one bit per cycle.
// Define UNIV_SHIFTER_ROTATE_EN to build ROTL/ROTR; otherwise they complete as HOLD.
module univ_shifter
  import univ_shifter_pkg::*;
#(
  parameter int unsigned         WIDTH   = 8,
  parameter logic [WIDTH-1:0]    RST_VAL = '0,
  localparam int unsigned        CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_q, ser_d;

  logic             is_shift;
  logic [CNT_W-1:0] amt_clamped;
  logic             step_left;
  logic             step_rot;
  logic             step_ser;
  logic [WIDTH-1:0] step_data;

  always_comb begin
    is_shift = (mode == MODE_SHL) || (mode == MODE_SHR)
`ifdef UNIV_SHIFTER_ROTATE_EN
               || (mode == MODE_ROTL) || (mode == MODE_ROTR)
`endif
               ;
    amt_clamped = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;
    step_left   = (mode_q == MODE_SHL) || (mode_q == MODE_ROTL);
`ifdef UNIV_SHIFTER_ROTATE_EN
    step_rot    = (mode_q == MODE_ROTL) || (mode_q == MODE_ROTR);
`else
    step_rot    = 1'b0;
`endif
  end

  always_comb begin
    step_ser  = 1'b0;
    step_data = WIDTH'(shift_step(MAX_W'(data_q), WIDTH, step_left, step_rot,
                                  ser_in, step_ser));
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DONE;
          if (mode == MODE_LOAD) begin
            data_d = load_data;
          end else if (is_shift && (amount != '0)) begin
            state_d = ST_SHIFT;
            cnt_d   = amt_clamped;
            mode_d  = mode_e'(mode);
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_data;
        ser_d  = step_ser;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      data_q  <= RST_VAL;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
    end
  end

  assign data_out = data_q;
  assign ser_out  = ser_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shifter.sv
// Self-checking bench for univ_shifter (WIDTH=8, RST_VAL=0) against an arithmetic model.
`timescale 1ns/1ps
module tb_univ_shifter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic [WIDTH-1:0] data_out;
  logic             ser_out;
  logic             busy;
  logic             done;

  int          checks = 0;
  int          errors = 0;
  int unsigned m_data = 0;
  logic        m_ser  = 1'b0;

  univ_shifter #(.WIDTH(WIDTH), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
    .load_data(load_data), .ser_in(ser_in), .data_out(data_out),
    .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Whole-operation model: final register value, last exiting bit, cycles spent busy.
  task automatic model_op(input logic [2:0] md, input int unsigned amt, input logic [7:0] ld,
                          input logic sin, output int unsigned cycles);
    int unsigned n;
    int unsigned outb;
    bit rot_en;
`ifdef UNIV_SHIFTER_ROTATE_EN
    rot_en = 1'b1;
`else
    rot_en = 1'b0;
`endif
    n = (amt > WIDTH) ? WIDTH : amt;
    cycles = 1;
    if (md == 3'd1) begin
      m_data = ld;
    end else if ((md == 3'd2 || md == 3'd3 || (rot_en && (md == 3'd4 || md == 3'd5))) && n > 0) begin
      cycles = n + 1;
      for (int unsigned i = 0; i < n; i++) begin
        case (md)
          3'd2: begin outb = m_data / 128; m_data = (m_data * 2 + sin) % 256; end
          3'd3: begin outb = m_data % 2;   m_data = m_data / 2 + sin * 128; end
          3'd4: begin outb = m_data / 128; m_data = (m_data * 2 + outb) % 256; end
          default: begin outb = m_data % 2; m_data = m_data / 2 + outb * 128; end
        endcase
        m_ser = outb[0];
      end
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle again.
  task automatic run_op(input string tag, input logic [2:0] md, input int unsigned amt,
                        input logic [7:0] ld, input logic sin, input bit poke);
    int unsigned cyc;
    model_op(md, amt, ld, sin, cyc);
    mode = md; amount = CNT_W'(amt); load_data = ld; ser_in = sin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int unsigned k = 0; k < cyc; k++) begin
      check({tag, "/busy"}, busy, 1'b1);
      check({tag, "/done"}, done, k == cyc - 1);
      if (k == cyc - 1) begin
        check({tag, "/data"}, data_out, m_data);
        check({tag, "/ser"}, ser_out, m_ser);
      end
      mode = 3'($urandom); amount = CNT_W'($urandom); load_data = 8'($urandom);
      start = poke && (k == 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "/idle_busy"}, busy, 1'b0);
    check({tag, "/idle_done"}, done, 1'b0);
    check({tag, "/idle_data"}, data_out, m_data);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = '0; amount = '0; load_data = '0; ser_in = 1'b0;
    #2;
    check("rst/data", data_out, 8'h00);
    check("rst/busy", busy, 1'b0);
    check("rst/done", done, 1'b0);
    check("rst/ser", ser_out, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_op("load_a5", 3'd1, 0, 8'hA5, 1'b0, 1'b0);
    run_op("load_81", 3'd1, 0, 8'h81, 1'b0, 1'b0);
    run_op("shl3", 3'd2, 3, 8'h00, 1'b1, 1'b0);
    check("shl3/value", data_out, 8'h0F);
    run_op("load_01", 3'd1, 0, 8'h01, 1'b0, 1'b0);
    run_op("rotr1", 3'd5, 1, 8'h00, 1'b0, 1'b0);
`ifdef UNIV_SHIFTER_ROTATE_EN
    check("rotr1/value", data_out, 8'h80);
`else
    check("rotr1/value", data_out, 8'h01);
`endif
    run_op("load_ff", 3'd1, 0, 8'hFF, 1'b0, 1'b0);
    run_op("shr15_poke", 3'd3, 15, 8'h00, 1'b0, 1'b1);
    check("shr15/value", data_out, 8'h00);
    run_op("shl0", 3'd2, 0, 8'h00, 1'b1, 1'b0);
    run_op("rsvd7", 3'd7, 5, 8'h3C, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), $urandom_range(0, 15),
             8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a shift: immediate clear, no done afterwards.
    run_op("load_ff2", 3'd1, 0, 8'hFF, 1'b0, 1'b0);
    mode = 3'd2; amount = CNT_W'(6); ser_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst/busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst/data", data_out, 8'h00);
    check("midrst/busy", busy, 1'b0);
    check("midrst/done", done, 1'b0);
    check("midrst/ser", ser_out, 1'b0);
    m_data = 0; m_ser = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check("midrst/no_done", done, 1'b0);
      @(posedge clk); #1;
    end
    run_op("post_rst", 3'd2, 2, 8'h00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shifter.md
UNIV_SHIFTER -- requirements
Module: univ_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits, legal range 2..64.
REQ-002 SHALL have parameter RST_VAL, default 0, WIDTH-bit value loaded into data_out on reset.
REQ-003 SHALL have localparam CNT_W = $clog2(WIDTH+1), the width of the amount port.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-007 SHALL have port mode, input, 3 bits: operation code, sampled with start.
REQ-008 SHALL have port amount, input, CNT_W bits: shift/rotate step count, sampled with start.
REQ-009 SHALL have port load_data, input, WIDTH bits: parallel load value, sampled with start.
REQ-010 SHALL have port ser_in, input, 1 bit: serial fill bit, sampled on every shift edge.
REQ-011 SHALL have port data_out, output, WIDTH bits: register contents.
REQ-012 SHALL have port ser_out, output, 1 bit: last bit shifted or rotated out.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE, with done = (state == DONE).
REQ-016 Mode codes SHALL be: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROTL, 5 ROTR; codes 6 and 7 SHALL behave as HOLD.
REQ-017 On edge E0 with start=1 in IDLE: for LOAD, SHALL set data_out to load_data and go to DONE.
REQ-018 On edge E0 for HOLD, for reserved codes, or for a shift/rotate with amount=0: SHALL leave data unchanged and go to DONE.
REQ-019 On edge E0 for a shift/rotate with amount n>0: SHALL latch min(n, WIDTH) into the step counter, latch the mode, and go to SHIFT with data unchanged.
REQ-020 In SHIFT, each edge SHALL perform exactly one 1-bit step and decrement the counter; on the step that takes the counter to 0, SHALL go to DONE.
REQ-021 Latency SHALL be: shifts on edges E1..En, done high in the cycle after En, IDLE again after En+1.
REQ-022 SHL SHALL be data <= {data[WIDTH-2:0], ser_in} with ser_out <= data[WIDTH-1].
REQ-023 SHR SHALL be data <= {ser_in, data[WIDTH-1:1]} with ser_out <= data[0].
REQ-024 ROTL/ROTR SHALL feed the exiting bit back in place of ser_in, and ser_out SHALL take the exiting bit.
REQ-025 ser_out SHALL change only on step edges and hold otherwise, including across LOAD.
REQ-026 start while busy SHALL be ignored with no queuing; start held high SHALL launch a new operation on the first edge in IDLE.
REQ-027 amount > WIDTH SHALL be clamped to WIDTH, so that SHL by WIDTH with ser_in=0 yields all zeros.
REQ-028 mode, amount and load_data changes during SHIFT SHALL have no effect on the operation in progress.

Reset
REQ-029 rst low SHALL immediately force state=IDLE, data_out=RST_VAL, ser_out=0, counter=0, busy=0, done=0, independent of clk.
REQ-030 Reset mid-operation SHALL abort it with no done pulse.
REQ-031 Normal operation SHALL resume on the first rising edge after rst goes high.

Configuration
REQ-032 Macro UNIV_SHIFTER_ROTATE_EN defined SHALL compile in the ROTL/ROTR datapath.
REQ-033 Without UNIV_SHIFTER_ROTATE_EN, modes 4 and 5 SHALL behave as HOLD, completing through DONE with data unchanged, and SHALL synthesize no rotate logic.

Structure
REQ-034 Package univ_shifter_pkg SHALL hold the mode enum typedef (mode_e), the FSM state enum typedef, and the mode code constants.
REQ-035 No sub-module SHALL be used; the single-step datapath SHALL be one function in univ_shifter_pkg.

Verification (WIDTH=8, RST_VAL=0)
REQ-036 Bench SHALL cover reset: rst low mid-SHIFT -> data_out=0x00, busy=0, done=0, ser_out=0 with no clock edge needed.
REQ-037 Bench SHALL cover load: LOAD 0xA5 -> data_out=0xA5 after E0, done high exactly one cycle, busy high for 1 cycle.
REQ-038 Bench SHALL cover shift left: LOAD 0x81, then SHL amount=3 with ser_in=1 -> data_out=0x0F after E3, ser_out=0, done in the cycle after E3.
REQ-039 Bench SHALL cover rotate right (ROTATE_EN defined): LOAD 0x01, then ROTR amount=1 -> 0x80, ser_out=1.
REQ-040 Bench SHALL cover rotate as HOLD (ROTATE_EN undefined): ROTR on 0x01 -> data_out stays 0x01 and done pulses.
REQ-041 Bench SHALL cover clamp and ignored start: SHR amount=15 with ser_in=0 on 0xFF -> 0x00 after 8 shifts; a start pulsed during SHIFT -> no extra operation or done.
